// File: rtl/uart_ram_cmd_ctrl.sv
// Command sequencer between the UART receiver and the 64x1 RAM under test: READ/WRITE/FILL/DUMP opcodes.
// Optional macro UART_CMD_ACK_EN: WRITE and FILL finish by sending ACK_BYTE on the tx handshake.
//
// state       | meaning
// IDLE        | waiting for an opcode byte
// GET_ARG     | WRITE/FILL waiting for the data byte, timeout running
// WRITE       | single ram_we pulse at the latched address
// FILL        | ram_we every cycle, address sweeping 0..max
// RD_SAMPLE   | address stable for a cycle, sample ram_rdata
// DUMP_RD     | shift in one bit per cycle, 8 bits per byte
// TX          | tx_valid held until accepted
// ACK         | load ACK_BYTE into the tx register
module uart_ram_cmd_ctrl #(
    parameter int          ADDR_WIDTH = 6,
    parameter int          TIMEOUT    = 1024,
    parameter logic [7:0]  ACK_BYTE   = 8'hA5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  baud_edge_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_ready_i,
    input  logic                  rx_ferr_i,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic                  ram_wdata_o,
    input  logic                  ram_rdata_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  busy_o,
    output logic                  err_o,
    output logic [1:0]            err_code_o
);

    localparam int AW = ADDR_WIDTH;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
`ifdef UART_CMD_ACK_EN
    localparam logic ACK_EN = 1'b1;
`else
    localparam logic ACK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_GET_ARG, S_WRITE, S_FILL, S_RD_SAMPLE, S_DUMP_RD, S_TX, S_ACK
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            wdata_q, wdata_d;
    logic            fill_q, fill_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic            dump_q, dump_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
    logic            err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= 1'b0;
            fill_q     <= 1'b0;
            tmo_q      <= '0;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            dump_q     <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            fill_q     <= fill_d;
            tmo_q      <= tmo_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            dump_q     <= dump_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        fill_d     = fill_q;
        tmo_d      = tmo_q;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        dump_d     = dump_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        // Framing error beats a simultaneous byte; bytes outside IDLE/GET_ARG are overruns.
        if (rx_ferr_i) begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
        end else if (rx_ready_i && state_q != S_IDLE && state_q != S_GET_ARG) begin
            err_d      = 1'b1;
            err_code_d = 2'd3;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_ready_i && !rx_ferr_i) begin
                    addr_d   = AW'(rx_data_i[5:0]);
                    fill_d   = rx_data_i[7];
                    tmo_d    = '0;
                    bitcnt_d = '0;
                    shift_d  = '0;
                    case (rx_data_i[7:6])
                        2'b00:   state_d = S_RD_SAMPLE;
                        2'b11: begin
                            addr_d  = '0;
                            state_d = S_DUMP_RD;
                        end
                        default: state_d = S_GET_ARG;
                    endcase
                end
            end
            S_GET_ARG: begin
                if (rx_ferr_i) begin
                    state_d = S_IDLE;
                end else if (rx_ready_i) begin
                    wdata_d = rx_data_i[0];
                    if (fill_q) begin
                        addr_d  = '0;
                        state_d = S_FILL;
                    end else begin
                        state_d = S_WRITE;
                    end
                end else if (baud_edge_i) begin
                    if (tmo_q == TW'(TIMEOUT - 1)) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd2;
                        state_d    = S_IDLE;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            S_WRITE: state_d = ACK_EN ? S_ACK : S_IDLE;
            S_FILL: begin
                addr_d = addr_q + AW'(1);
                if (addr_q == {AW{1'b1}}) state_d = ACK_EN ? S_ACK : S_IDLE;
            end
            S_RD_SAMPLE: begin
                tx_data_d  = {7'b0, ram_rdata_i};
                tx_valid_d = 1'b1;
                dump_d     = 1'b0;
                state_d    = S_TX;
            end
            S_DUMP_RD: begin
                shift_d  = {ram_rdata_i, shift_q[7:1]};
                addr_d   = addr_q + AW'(1);
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    tx_data_d  = {ram_rdata_i, shift_q[7:1]};
                    tx_valid_d = 1'b1;
                    dump_d     = 1'b1;
                    state_d    = S_TX;
                end
            end
            S_TX: begin
                if (tx_ready_i) begin
                    tx_valid_d = 1'b0;
                    // A dump is finished once the address has wrapped back to zero.
                    state_d    = (dump_q && addr_q != '0) ? S_DUMP_RD : S_IDLE;
                end
            end
            S_ACK: begin
                tx_data_d  = ACK_BYTE;
                tx_valid_d = 1'b1;
                dump_d     = 1'b0;
                state_d    = S_TX;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q != S_IDLE);
        ram_we_o    = (state_q == S_WRITE) || (state_q == S_FILL);
        ram_addr_o  = addr_q;
        ram_wdata_o = wdata_q;
        tx_data_o   = tx_data_q;
        tx_valid_o  = tx_valid_q;
        err_o       = err_q;
        err_code_o  = err_code_q;
    end

endmodule

// File: tb/tb_uart_ram_cmd_ctrl.sv
// Bench for uart_ram_cmd_ctrl: command table plus hand sequences, tx bytes checked via a scoreboard queue.
// Follows UART_CMD_ACK_EN the same way the design does.
module tb_uart_ram_cmd_ctrl;
    localparam int         AW   = 6;
    localparam int         TMO  = 16;
    localparam logic [7:0] ACKB = 8'hA5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          baud_edge = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready = 1'b0;
    logic          rx_ferr = 1'b0;
    logic          tx_ready = 1'b1;
    logic [AW-1:0] ram_addr;
    logic          ram_we, ram_wdata, ram_rdata;
    logic [7:0]    tx_data;
    logic          tx_valid, busy, err;
    logic [1:0]    err_code;

    logic [63:0]   ram;
    logic [63:0]   exp_mem = '0;
    logic [7:0]    exp_q[$];

    int            chk_cnt = 0;
    int            pass_cnt = 0;
    int            err_cnt = 0;
    logic [1:0]    err_last = 2'd0;
    int            we_cnt = 0;
    logic [AW-1:0] we_addr = '0;
    logic          we_data = 1'b0;

    typedef struct {
        logic [7:0] op;
        logic [7:0] arg;
        logic       has_arg;
        logic       exp_v;
        logic [7:0] exp_b;
    } vec_t;
    vec_t tbl[13];

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;
    assign ram_rdata = ram[ram_addr];

    uart_ram_cmd_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT(TMO), .ACK_BYTE(ACKB)) dut (
        .clk_i(clk), .rst_ni(rst_n), .baud_edge_i(baud_edge),
        .rx_data_i(rx_data), .rx_ready_i(rx_ready), .rx_ferr_i(rx_ferr),
        .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .busy_o(busy), .err_o(err), .err_code_o(err_code)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic send_raw(input logic [7:0] b, input logic rdy, input logic ferr, input logic tick);
        @(posedge clk); #1;
        rx_data = b; rx_ready = rdy; rx_ferr = ferr; baud_edge = tick;
        @(posedge clk); #1;
        rx_ready = 1'b0; rx_ferr = 1'b0; baud_edge = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_raw(b, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 baud_edge = 1'b1;
        end
        @(posedge clk); #1 baud_edge = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            chk_cnt++;
            $display("FAIL %s: still busy after %0d cycles, want idle", name, n);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk_cnt++;
            $display("FAIL %s: %0d tx bytes never arrived, want 0 outstanding", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic push_ack(input logic [7:0] op);
`ifdef UART_CMD_ACK_EN
        if (op[7:6] == 2'b01 || op[7:6] == 2'b10) exp_q.push_back(ACKB);
`else
        if (op[7:6] == 2'b01 && op[7:6] == 2'b10) exp_q.push_back(ACKB);
`endif
    endtask

    task automatic do_cmd(input logic [7:0] op, input logic [7:0] arg, input logic has_arg,
                          input logic exp_v, input logic [7:0] exp_b);
        push_ack(op);
        if (exp_v) exp_q.push_back(exp_b);
        send_byte(op);
        if (has_arg) send_byte(arg);
        if (op[7:6] == 2'b01) exp_mem[op[5:0]] = arg[0];
        if (op[7:6] == 2'b10) exp_mem = {64{arg[0]}};
        wait_idle("cmd_idle");
        wait_drain("cmd_drain");
    endtask

    task automatic push_dump();
        for (int i = 0; i < 8; i++) exp_q.push_back(exp_mem[i*8 +: 8]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
        $fatal(1);
    end

    initial begin
        int w0, e0, n;
        fork
            forever begin
                @(negedge clk);
                if (err) begin err_cnt++; err_last = err_code; end
                if (ram_we) begin we_cnt++; we_addr = ram_addr; we_data = ram_wdata; end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        chk_cnt++;
                        $display("FAIL tx_unexpected: got byte 0x%0h, want no byte", tx_data);
                    end else begin
                        check("tx_byte", 64'(tx_data), 64'(exp_q.pop_front()));
                    end
                end
            end
        join_none

        tbl[0]  = '{8'h45, 8'h01, 1'b1, 1'b0, 8'h00};
        tbl[1]  = '{8'h05, 8'h00, 1'b0, 1'b1, 8'h01};
        tbl[2]  = '{8'h06, 8'h00, 1'b0, 1'b1, 8'h00};
        tbl[3]  = '{8'h7F, 8'h01, 1'b1, 1'b0, 8'h00};
        tbl[4]  = '{8'h3F, 8'h00, 1'b0, 1'b1, 8'h01};
        tbl[5]  = '{8'h40, 8'hFF, 1'b1, 1'b0, 8'h00};
        tbl[6]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h01};
        tbl[7]  = '{8'h45, 8'hFE, 1'b1, 1'b0, 8'h00};
        tbl[8]  = '{8'h05, 8'h00, 1'b0, 1'b1, 8'h00};
        tbl[9]  = '{8'h49, 8'h03, 1'b1, 1'b0, 8'h00};
        tbl[10] = '{8'h09, 8'h00, 1'b0, 1'b1, 8'h01};
        tbl[11] = '{8'h08, 8'h00, 1'b0, 1'b1, 8'h00};
        tbl[12] = '{8'h3E, 8'h00, 1'b0, 1'b1, 8'h00};

        // reset values
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_we", 64'(ram_we), 64'd0);
        check("rst_addr", 64'(ram_addr), 64'd0);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);

        // single write pulse then read back
        w0 = we_cnt;
        do_cmd(8'h45, 8'h01, 1'b1, 1'b0, 8'h00);
        check("wr_pulses", 64'(we_cnt - w0), 64'd1);
        check("wr_addr", 64'(we_addr), 64'd5);
        check("wr_data", 64'(we_data), 64'd1);
        do_cmd(8'h05, 8'h00, 1'b0, 1'b1, 8'h01);

        // fill ones, dump all-ones
        w0 = we_cnt;
        do_cmd(8'h80, 8'h01, 1'b1, 1'b0, 8'h00);
        check("fill_pulses", 64'(we_cnt - w0), 64'd64);
        check("fill_ram", ram, {64{1'b1}});
        push_dump();
        send_byte(8'hC0);
        wait_idle("dump_idle");
        wait_drain("dump_drain");

        // byte arriving mid-dump is an overrun; dump still completes
        e0 = err_cnt;
        push_dump();
        send_byte(8'hC0);
        repeat (3) @(posedge clk);
        send_byte(8'h11);
        wait_idle("ovr_idle");
        wait_drain("ovr_drain");
        check("ovr_err_cnt", 64'(err_cnt - e0), 64'd1);
        check("ovr_err_code", 64'(err_last), 64'd3);

        // argument timeout: one tick short does not fire, the next one does
        e0 = err_cnt; w0 = we_cnt;
        send_byte(8'h41);
        ticks(TMO - 1);
        @(negedge clk);
        check("tmo_early_busy", 64'(busy), 64'd1);
        check("tmo_early_err", 64'(err_cnt - e0), 64'd0);
        ticks(1);
        repeat (2) @(negedge clk);
        check("tmo_err_cnt", 64'(err_cnt - e0), 64'd1);
        check("tmo_err_code", 64'(err_last), 64'd2);
        check("tmo_busy", 64'(busy), 64'd0);
        check("tmo_no_write", 64'(we_cnt - w0), 64'd0);
        check("tmo_ram", ram, exp_mem);

        // byte on the same edge the timeout would fire: byte wins
        e0 = err_cnt; w0 = we_cnt;
        send_byte(8'h42);
        ticks(TMO - 1);
        push_ack(8'h42);
        send_raw(8'h00, 1'b1, 1'b0, 1'b1);
        exp_mem[2] = 1'b0;
        wait_idle("edge_idle");
        wait_drain("edge_drain");
        check("edge_err_cnt", 64'(err_cnt - e0), 64'd0);
        check("edge_pulses", 64'(we_cnt - w0), 64'd1);
        check("edge_addr", 64'(we_addr), 64'd2);
        check("edge_data", 64'(we_data), 64'd0);

        // framing error discards the argument; ferr beats rx_ready in IDLE
        e0 = err_cnt; w0 = we_cnt;
        send_byte(8'h43);
        send_raw(8'h01, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("ferr_busy", 64'(busy), 64'd0);
        check("ferr_err_cnt", 64'(err_cnt - e0), 64'd1);
        check("ferr_code", 64'(err_last), 64'd1);
        check("ferr_no_write", 64'(we_cnt - w0), 64'd0);
        send_raw(8'h05, 1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("ferr_rdy_busy", 64'(busy), 64'd0);
        check("ferr_rdy_err_cnt", 64'(err_cnt - e0), 64'd2);
        check("ferr_rdy_code", 64'(err_last), 64'd1);

        // reset in the middle of a fill
        send_byte(8'h80);
        send_byte(8'h01);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rstfill_we", 64'(ram_we), 64'd0);
        check("rstfill_busy", 64'(busy), 64'd0);
        check("rstfill_tx_valid", 64'(tx_valid), 64'd0);
        w0 = we_cnt;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (80) @(negedge clk);
        check("rstfill_no_more_we", 64'(we_cnt - w0), 64'd0);
        check("rstfill_idle", 64'(busy), 64'd0);

        do_cmd(8'h80, 8'h00, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 13; i++)
            do_cmd(tbl[i].op, tbl[i].arg, tbl[i].has_arg, tbl[i].exp_v, tbl[i].exp_b);

        // dump with the transmitter stalled: first byte must hold
        push_dump();
        tx_ready = 1'b0;
        send_byte(8'hC0);
        n = 0;
        while (!tx_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid_seen", 64'(tx_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(tx_valid), 64'd1);
            check("stall_data", 64'(tx_data), 64'(exp_mem[7:0]));
        end
        @(posedge clk); #1 tx_ready = 1'b1;
        wait_idle("stall_idle");
        wait_drain("stall_drain");
        check("final_ram", ram, exp_mem);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
